// File: rtl/gaussian_pkg.sv
// Shared definitions for the Gaussian sampler arithmetic: mode encoding,
// signed range limits and parameter legality rules.
package gaussian_pkg;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_MAC = 1'b1
  } mode_e;

  // Most negative (neg=1) or most positive (neg=0) value of a w-bit signed word.
  function automatic logic signed [63:0] sat_limit(input int unsigned w, input logic neg);
    logic signed [63:0] half;
    half = 64'sd1 <<< (w - 1);
    return neg ? -half : half - 64'sd1;
  endfunction

  function automatic logic params_ok(input int unsigned lat, input int unsigned shift,
                                     input int unsigned acc_w, input int unsigned out_w);
    return (lat >= 3) && (shift < acc_w) && (out_w <= acc_w);
  endfunction

endpackage

// File: rtl/gaussian_round_sat.sv
// Combinational round-half-up arithmetic right shift followed by signed
// saturation to OUT_W bits.
module gaussian_round_sat
  import gaussian_pkg::*;
#(
  parameter int unsigned IN_W  = 42,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 34
) (
  input  logic [IN_W-1:0]  v,
  output logic [OUT_W-1:0] r,
  output logic             sat
);

  localparam int unsigned EW = IN_W + 1;

  // One extra bit so adding the rounding constant cannot wrap.
  logic signed [EW-1:0] ve;
  logic signed [EW-1:0] rs;
  logic signed [63:0]   lim;
  logic                 ovf;

  assign ve = {v[IN_W-1], v};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
    assign rs = (ve + HALF) >>> SHIFT;
  end else begin : g_pass
    assign rs = ve;
  end

  always_comb begin
    lim = sat_limit(OUT_W, rs[EW-1]);
    ovf = !((&rs[EW-1:OUT_W-1]) || !(|rs[EW-1:OUT_W-1]));
    r   = ovf ? lim[OUT_W-1:0] : rs[OUT_W-1:0];
    sat = ovf;
  end

endmodule

// File: rtl/gaussian_smac_pipe.sv
// Signed multiply / multiply-accumulate pipeline with valid/ready handshake,
// configurable latency, and rounded, saturated output.
module gaussian_smac_pipe
  import gaussian_pkg::*;
#(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 18,
  parameter int unsigned LAT   = 3,
  parameter int unsigned GUARD = 8,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_mac,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned ACC_W = A_W + B_W + GUARD;

  if (!params_ok(LAT, SHIFT, ACC_W, OUT_W)) begin : g_bad_params
    $error("gaussian_smac_pipe: illegal LAT/SHIFT/OUT_W combination");
  end

  typedef struct packed {
    logic                  v;
    mode_e                 mode;
    logic                  clr;
    logic signed [P_W-1:0] p;
  } stg_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                  s1_v;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;
  mode_e                 s1_mode;
  logic                  s1_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= MODE_MUL;
      s1_clr  <= 1'b0;
    end else if (adv) begin
      s1_v    <= in_valid;
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_mode <= mode_e'(in_mac);
      s1_clr  <= in_clr;
    end
  end

  stg_t stg [2:LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg[2] <= '0;
    end else if (adv) begin
      stg[2].v    <= s1_v;
      stg[2].mode <= s1_mode;
      stg[2].clr  <= s1_clr;
      stg[2].p    <= P_W'(s1_a) * P_W'(s1_b);
    end
  end

  for (genvar i = 3; i < LAT; i++) begin : g_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      stg[i] <= '0;
      else if (adv) stg[i] <= stg[i-1];
    end
  end

  stg_t                    last;
  logic signed [P_W-1:0]   last_p;
  logic signed [ACC_W-1:0] pe;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] sel;
  logic [OUT_W-1:0]        rs_data;
  logic                    rs_sat;

  assign last   = stg[LAT-1];
  assign last_p = last.p;
  assign pe     = ACC_W'(last_p);

  // acc_nxt equals acc unless a valid MAC beat is entering the output stage.
  always_comb begin
    acc_nxt = acc;
    if (last.v && last.mode == MODE_MAC) begin
      acc_nxt = last.clr ? pe : acc + pe;
    end
    sel = (last.mode == MODE_MAC) ? acc_nxt : pe;
  end

  gaussian_round_sat #(
    .IN_W (ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .v  (sel),
    .r  (rs_data),
    .sat(rs_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      acc       <= acc_nxt;
      out_valid <= last.v;
      out_data  <= rs_data;
      out_sat   <= rs_sat;
    end
  end

endmodule

// File: tb/tb_gaussian_smac_pipe.sv
// Bench for gaussian_smac_pipe: three parameterisations checked against a
// queue-based arithmetic model plus literal directed expectations.
module tb_gaussian_smac_pipe;

  localparam int SH [3] = '{0, 4, 0};
  localparam int OW [3] = '{34, 8, 34};
  localparam int LT [3] = '{3, 3, 5};

  typedef struct {
    longint r;
    logic   s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = '0;
  logic        ordy = 1'b1;
  logic [15:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        in_mac = 1'b0;
  logic        in_clr = 1'b0;

  logic ov0, ov1, ov2, ir0, ir1, ir2, os0, os1, os2;
  logic [33:0] od0, od2;
  logic [7:0]  od1;
  logic [2:0]  ov, ir, os;
  longint      od [3];

  assign ov = {ov2, ov1, ov0};
  assign ir = {ir2, ir1, ir0};
  assign os = {os2, os1, os0};
  always_comb begin
    od[0] = longint'($signed(od0));
    od[1] = longint'($signed(od1));
    od[2] = longint'($signed(od2));
  end

  always #5 clk = ~clk;

  gaussian_smac_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
    .in_mac(in_mac), .in_clr(in_clr), .out_valid(ov0), .out_ready(ordy),
    .out_data(od0), .out_sat(os0)
  );

  gaussian_smac_pipe #(.SHIFT(4), .OUT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
    .in_mac(in_mac), .in_clr(in_clr), .out_valid(ov1), .out_ready(ordy),
    .out_data(od1), .out_sat(os1)
  );

  gaussian_smac_pipe #(.LAT(5)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
    .in_mac(in_mac), .in_clr(in_clr), .out_valid(ov2), .out_ready(ordy),
    .out_data(od2), .out_sat(os2)
  );

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  longint macc [3];
  exp_t   expq [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Reference: accumulator modulo 2^42, floor-shift after adding half, clamp.
  function automatic longint wrap42(input longint x);
    return (x <<< 22) >>> 22;
  endfunction

  function automatic void model_push(input int d, input longint a, input longint b,
                                     input logic mac, input logic clr);
    longint p, v, r, mx, mn;
    logic   s;
    p = a * b;
    if (mac) begin
      macc[d] = clr ? p : wrap42(macc[d] + p);
      v = macc[d];
    end else begin
      v = p;
    end
    r  = (SH[d] > 0) ? ((v + (64'sd1 <<< (SH[d] - 1))) >>> SH[d]) : v;
    mx = (64'sd1 <<< (OW[d] - 1)) - 1;
    mn = -mx - 1;
    s  = 1'b0;
    if (r > mx) begin
      r = mx; s = 1'b1;
    end else if (r < mn) begin
      r = mn; s = 1'b1;
    end
    expq[d].push_back('{r, s});
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) begin
      macc[d] = 0;
      expq[d].delete();
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          if (expq[d].size() == 0) begin
            chk($sformatf("d%0d_spurious_out", d), 1, 0);
          end else begin
            chk($sformatf("d%0d_data", d), od[d], expq[d][0].r);
            chk($sformatf("d%0d_sat", d), longint'(os[d]), longint'(expq[d][0].s));
            if (ordy) void'(expq[d].pop_front());
          end
        end
        if (iv[d] && ir[d])
          model_push(d, longint'($signed(in_a)), longint'($signed(in_b)), in_mac, in_clr);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input longint a, input longint b,
                      input logic mac, input logic clr);
    int n;
    n = 0;
    in_a = 16'(a); in_b = 18'(b); in_mac = mac; in_clr = clr;
    iv[d] = 1'b1;
    @(negedge clk);
    while (!ir[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ir[d]) chk($sformatf("d%0d_send_timeout", d), 0, 1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input longint val, input logic sat,
                          input string nm, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[d] && n < 30);
    if (!ov[d]) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      if (lat > 0) chk({nm, "_lat"}, n, lat);
      chk({nm, "_data"}, od[d], val);
      chk({nm, "_sat"}, longint'(os[d]), longint'(sat));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    longint got [$];
    logic   saw_stall;
    int     run, best, t0;

    model_clear();
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_valid", d), longint'(ov[d]), 0);
      chk($sformatf("d%0d_rst_ready", d), longint'(ir[d]), 1);
      chk($sformatf("d%0d_rst_data", d), od[d], 0);
      chk($sformatf("d%0d_rst_sat", d), longint'(os[d]), 0);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    send(0, -32768, -131072, 1'b0, 1'b0); wait_out(0, 64'sd4294967296, 1'b0, "mul_min", 3);
    send(0, -1, 5, 1'b0, 1'b0);           wait_out(0, -5, 1'b0, "mul_neg", 3);
    send(0, 3, 4, 1'b1, 1'b1);            wait_out(0, 12, 1'b0, "mac0", 3);
    send(0, -2, 5, 1'b1, 1'b0);           wait_out(0, 2, 1'b0, "mac1", 3);
    send(0, 7, 1, 1'b1, 1'b0);            wait_out(0, 9, 1'b0, "mac2", 3);
    send(0, 10, 10, 1'b0, 1'b0);          wait_out(0, 100, 1'b0, "mul_mid", 3);
    send(0, 1, 1, 1'b1, 1'b0);            wait_out(0, 10, 1'b0, "mac_keep", 3);

    send(1, 100, 3, 1'b0, 1'b0);     wait_out(1, 19, 1'b0, "sh_round", 3);
    send(1, 1000, 100, 1'b0, 1'b0);  wait_out(1, 127, 1'b1, "sh_satp", 3);
    send(1, -1000, 100, 1'b0, 1'b0); wait_out(1, -128, 1'b1, "sh_satn", 3);
    send(1, -24, 1, 1'b0, 1'b0);     wait_out(1, -1, 1'b0, "sh_half", 3);

    send(2, -1, 5, 1'b0, 1'b0);      wait_out(2, -5, 1'b0, "lat5", 5);

    // Backpressure: six beats, out_ready low for cycles 3-6.
    saw_stall = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(0, i, 2, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 ordy = 1'b0;
        repeat (4) @(posedge clk);
        #1 ordy = 1'b1;
      end
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (!ir[0]) saw_stall = 1'b1;
        if (ov[0] && ordy) got.push_back(od[0]);
      end
    join
    chk("bp_stall_seen", longint'(saw_stall), 1);
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("bp_out%0d", i), got[i], 2 * i);
    @(posedge clk); #1;

    // Throughput with LAT=5: eight beats, one per cycle, one contiguous output run.
    run = 0; best = 0; t0 = cyc;
    fork
      for (int i = 0; i < 8; i++) send(2, i + 1, 3, 1'b0, 1'b0);
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        run = ov[2] ? run + 1 : 0;
        if (run > best) best = run;
      end
    join
    chk("tp_out_run", best, 8);
    @(posedge clk); #1;
    t0 = cyc - t0;
    chk("tp_cycles_nonzero", longint'(t0 > 0), 1);

    // Asynchronous reset mid-stream with acc = 50.
    send(0, 5, 10, 1'b1, 1'b1); wait_out(0, 50, 1'b0, "rst_pre_acc", 3);
    in_a = 16'd1; in_b = 18'd1; in_mac = 1'b0; in_clr = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1 in_a = 16'd2;
    @(posedge clk); #1 iv[0] = 1'b0;
    @(posedge clk); #2;
    chk("rst_pre_valid", longint'(ov[0]), 1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_async_valid", longint'(ov[0]), 0);
    chk("rst_async_ready", longint'(ir[0]), 1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send(0, 2, 3, 1'b1, 1'b0); wait_out(0, 6, 1'b0, "rst_acc_zero", 3);

    // Random traffic on all three instances, random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_a   = 16'($urandom);
      in_b   = 18'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_a = 16'($signed(5'($urandom)));
        in_b = 18'($signed(6'($urandom)));
      end
      in_mac = 1'($urandom);
      in_clr = ($urandom_range(0, 7) == 0);
      iv     = 3'($urandom);
      ordy   = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    iv = '0; ordy = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_drained", d), expq[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gaussian_smac_pipe.md
# gaussian_smac_pipe

Parametrised signed multiply / multiply-accumulate pipeline for the Gaussian sampler datapath. It replaces the fixed 16x18, 2-cycle signed multiplier with configurable operand widths and latency, a valid/ready handshake with full backpressure, and a per-beat MUL/MAC mode. The final stage rounds and saturates the result to a configurable output width. It sits between the sampler's coefficient/CDT arithmetic and downstream comparison logic, where both plain products and running dot-product sums are needed.

## Interface
- A_W, 16: multiplicand width (signed, two's complement)
- B_W, 18: multiplier width (signed)
- LAT, 3: pipeline latency in advancing cycles; must be ≥ 3
- GUARD, 8: accumulator guard bits; ACC_W = A_W + B_W + GUARD
- SHIFT, 0: arithmetic right shift applied at output, with round-half-up; range 0 .. ACC_W-1
- OUT_W, 34: output width (signed); the defaults reproduce the plain 34-bit product
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  pipeline accepts a beat this cycle
- in_a  in  A_W  multiplicand
- in_b  in  B_W  multiplier
- in_mac  in  1  0 = MUL (result is the product), 1 = MAC (result is the accumulator after the add)
- in_clr  in  1  MAC only: start a new sum (acc := product); ignored in MUL
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  rounded, saturated result
- out_sat  out  1  out_data was clipped this beat

## Operation
- Handshake: a beat transfers when valid and ready are both high in the same cycle. advance = !out_valid | out_ready, and in_ready = advance, combinationally.
- When advance is high, all stages shift together. When it is low, every stage, including each stage's valid bit and the accumulator, holds. No bubble collapsing.
- Stage 1 registers a, b, mac, clr and the valid bit. Stage 2 forms the full-precision signed product (A_W+B_W bits). Stages 3..LAT-1 are delay registers. Stage LAT performs accumulate, round and saturate into the output registers.
- Accumulator (ACC_W, signed) updates only when a valid MAC beat enters stage LAT:
  - clr = 1: acc := sext(product)
  - clr = 0: acc := acc + sext(product)
  - The add wraps modulo 2^ACC_W. GUARD sizes the accumulator so that 2^GUARD full-scale terms never wrap.
  - MUL beats leave acc untouched, so MUL and MAC beats can be interleaved.
- Selected value v is the sign-extended product (MUL) or the new acc (MAC).
- If SHIFT > 0, r = (v + 2^(SHIFT-1)) >>> SHIFT; otherwise r = v.
- Saturation:
  - r > 2^(OUT_W-1)-1: out_data = max, out_sat = 1.
  - r < -2^(OUT_W-1): out_data = min, out_sat = 1.
  - Otherwise out_data = r, out_sat = 0.
  - Saturation never feeds back into acc.
- The first MAC beat after reset with clr = 0 accumulates onto 0.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, out_data 0, out_sat 0, acc 0, in_ready 1 (out_valid is 0).
- Latency: a beat accepted at edge k appears on out_valid/out_data after edge k+LAT-1, provided advance stayed high. Each low-advance cycle adds exactly one cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Stall with the pipeline full: in_ready = 0. No beat is lost or duplicated, and order is preserved.
- Simultaneous output pop and input push in the same cycle: both occur.
- Reset asserted mid-stream: all in-flight beats are discarded immediately (asynchronous). out_valid drops in the same cycle, and acc clears. Operation resumes on the first edge after rst deasserts.
- in_a, in_b, in_mac and in_clr are don't-care when in_valid is low. Bubbles never touch acc.

## Structure
- Shared package gaussian_pkg holds:
  - the MAC/MUL mode encoding;
  - a function returning the signed min/max for a given width;
  - a parameter legality check (LAT ≥ 3, SHIFT < ACC_W, OUT_W ≤ ACC_W).
- Sub-module gaussian_round_sat: combinational round-half-up, shift and saturate, parameterised by IN_W, SHIFT and OUT_W. It is instantiated in stage LAT.
- The delay stages are a generate loop inside the top module.

## Test plan
- Defaults, MUL: a = 16'h8000 (-32768), b = 18'h20000 (-131072) → out_data = 4294967296, out_sat = 0, three cycles after acceptance. Repeat with a = -1, b = 5 → -5.
- MAC sequence, defaults: (3, 4, clr=1), (-2, 5), (7, 1) → 12, 2, 9. Then one MUL beat (10, 10) → 100. Then MAC (1, 1) → 10, which proves the MUL beat left acc unchanged.
- SHIFT = 4, OUT_W = 8, MUL:
  - 100 × 3 → 19, sat 0
  - 1000 × 100 → 127, sat 1
  - -1000 × 100 → -128, sat 1
  - -24 × 1 → -1 (round-half-up of -1.5)
- Backpressure: stream 6 MUL beats (a = i, b = 2) back-to-back, with out_ready low for cycles 3–6 → in_ready drops once the pipeline fills. Outputs are exactly 0, 2, 4, 6, 8, 10 in order, with no duplicates.
- Reset mid-stream: assert rst asynchronously between edges with 2 beats in flight and acc = 50 → out_valid is 0 before the next edge. After release, MAC (2, 3, clr=0) → 6.
- LAT = 5: the same MUL beat shows latency 5 and full throughput with out_ready held high.
